// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: arbitrates, drives the
// ALU from registered operands, and returns result/flags on a valid/ready channel.
//
// state | meaning
// IDLE  | waiting for a request; grant issued combinationally here
// EXEC  | ALU driven from operand registers; result and flags captured
// RESP  | response presented until rsp_valid && rsp_ready
module alu_arbiter #(
  parameter bit         RR_EN      = 1'b1,
  parameter logic [3:0] CMP_OPCODE = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] op0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [3:0] op1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt1,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_n,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_flags,
  output logic [3:0] flags_q,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic       last_grant;
  logic       owner_id;
  logic       win_valid;
  logic       win_id;
  logic [3:0] alu_flags;

  assign alu_flags = {alu_c, alu_z, alu_v, alu_n};
  assign busy      = (state != IDLE);

  // Grant is gated by rst so a reset cycle never accepts an operation.
  always_comb begin
    win_valid = 1'b0;
    win_id    = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0 && req1) begin
        win_valid = 1'b1;
        win_id    = RR_EN ? ~last_grant : 1'b0;
      end else if (req0) begin
        win_valid = 1'b1;
        win_id    = 1'b0;
      end else if (req1) begin
        win_valid = 1'b1;
        win_id    = 1'b1;
      end
    end
  end

  assign gnt0 = win_valid && !win_id;
  assign gnt1 = win_valid && win_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner_id   <= 1'b0;
      alu_opcode <= 4'h0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 8'h00;
      rsp_flags  <= 4'h0;
      flags_q    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            owner_id   <= win_id;
            alu_opcode <= win_id ? op1 : op0;
            alu_a      <= win_id ? a1 : a0;
            alu_b      <= win_id ? b1 : b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= (alu_opcode == CMP_OPCODE) ? 8'h00 : alu_out;
          rsp_flags  <= alu_flags;
          flags_q    <= alu_flags;
          rsp_valid  <= 1'b1;
          rsp_id     <= owner_id;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed operations push hand-computed
// responses; a monitor pops and compares on every response handshake.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] op0 = 4'h0, op1 = 4'h0;
  logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
  logic       rsp_ready = 1'b1;

  logic       gnt0, gnt1, rsp_valid, rsp_id, busy;
  logic [3:0] alu_opcode, rsp_flags, flags_q;
  logic [7:0] alu_a, alu_b, alu_out, rsp_result;
  logic       alu_c, alu_z, alu_v, alu_n;

  logic       fp_gnt0, fp_gnt1, fp_rsp_valid, fp_rsp_id, fp_busy;
  logic [3:0] fp_opcode, fp_rsp_flags, fp_flags_q;
  logic [7:0] fp_a, fp_b, fp_alu_out, fp_rsp_result;
  logic       fp_c, fp_z, fp_v, fp_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [12:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU: 0 add, 1/F subtract, 4 divide; returns {result, c, z, v, n}.
  function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v;
    r = 8'h00; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'h1, 4'hF: begin
        r = a - b; c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'h4: begin
        if (b == 8'h00) begin r = 8'hFF; v = 1'b1; end
        else r = a / b;
      end
      default: r = 8'h00;
    endcase
    return {r, c, (r == 8'h00), v, r[7]};
  endfunction

  assign {alu_out, alu_c, alu_z, alu_v, alu_n} = alu_model(alu_opcode, alu_a, alu_b);
  assign {fp_alu_out, fp_c, fp_z, fp_v, fp_n}  = alu_model(fp_opcode, fp_a, fp_b);

  alu_arbiter #(.RR_EN(1'b1), .CMP_OPCODE(4'b1111)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .flags_q(flags_q), .busy(busy)
  );

  alu_arbiter #(.RR_EN(1'b0), .CMP_OPCODE(4'b1111)) u_fp (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(fp_gnt0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(fp_gnt1),
    .alu_opcode(fp_opcode), .alu_a(fp_a), .alu_b(fp_b),
    .alu_out(fp_alu_out), .alu_c(fp_c), .alu_z(fp_z), .alu_v(fp_v), .alu_n(fp_n),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_result(fp_rsp_result), .rsp_flags(fp_rsp_flags), .flags_q(fp_flags_q), .busy(fp_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; holds the request until granted, then drops it next negedge.
  task automatic issue(input logic id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_res, input logic [3:0] exp_fl, input bit push_exp,
                       output int gcyc);
    bit got;
    got = 1'b0;
    gcyc = -1;
    if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (id ? gnt1 : gnt0) begin
        got = 1'b1;
        gcyc = cyc;
        if (push_exp) sb.push_back({id, exp_res, exp_fl});
      end
      @(negedge clk);
    end
    if (id) req1 = 1'b0; else req0 = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL grant_timeout: requester %0d got no grant, expected one within 20 cycles", id);
    end
  endtask

  // Entered at negedge T+1 with rsp_ready high: valid at T+2, flags visible and idle at T+3.
  task automatic after_op(input string name, input logic [3:0] exp_fq);
    #1; chk({name, "_nolate"}, rsp_valid, 1'b0);
    @(negedge clk); #1; chk({name, "_valid_t2"}, rsp_valid, 1'b1);
    @(negedge clk); #1; chk({name, "_flags_q"}, flags_q, exp_fq);
    chk({name, "_idle_t3"}, busy, 1'b0);
  endtask

  logic        hold_prev = 1'b0;
  logic [12:0] prev_rsp;
  logic [12:0] exp_e;

  always @(negedge clk) begin
    #1;
    if (hold_prev && !rst) begin
      chk("bp_valid_held", rsp_valid, 1'b1);
      chk("bp_fields_held", {rsp_id, rsp_result, rsp_flags}, prev_rsp);
    end
    hold_prev = rsp_valid && !rsp_ready && !rst;
    prev_rsp  = {rsp_id, rsp_result, rsp_flags};
    if (rsp_valid && rsp_ready && !rst) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got id %0d result %0h, expected no response", rsp_id, rsp_result);
      end else begin
        exp_e = sb.pop_front();
        chk("rsp_id", rsp_id, exp_e[12]);
        chk("rsp_result", rsp_result, exp_e[11:4]);
        chk("rsp_flags", rsp_flags, exp_e[3:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g0, g1, hs, fp_cnt;
    logic [1:0] pat;

    @(negedge clk); @(negedge clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_flags_q", flags_q, 4'h0);
    chk("rst_alu_drive", {alu_opcode, alu_a, alu_b}, 20'h0);
    chk("rst_rsp_fields", {rsp_id, rsp_result, rsp_flags}, 13'h0);
    @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 4'h0, 8'h7F, 8'h01, 8'h80, 4'b0011, 1'b1, g);
    after_op("add", 4'b0011);
    issue(1'b1, 4'hF, 8'h05, 8'h05, 8'h00, 4'b0100, 1'b1, g);
    after_op("cmp_eq", 4'b0100);
    issue(1'b0, 4'hF, 8'h09, 8'h03, 8'h00, 4'b0000, 1'b1, g);
    after_op("cmp_force", 4'b0000);
    issue(1'b1, 4'h0, 8'hFF, 8'h01, 8'h00, 4'b1100, 1'b1, g);
    after_op("add_carry", 4'b1100);

    // Back-pressure with requester 1 waiting behind the response.
    rsp_ready = 1'b0;
    issue(1'b0, 4'h0, 8'h01, 8'h02, 8'h03, 4'b0000, 1'b1, g);
    req1 = 1'b1; op1 = 4'h1; a1 = 8'h10; b1 = 8'h01;
    @(negedge clk); #1; chk("bp_valid_t2", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1; chk("bp_no_gnt1", gnt1, 1'b0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1; chk("bp_hs_no_gnt1", gnt1, 1'b0);
    hs = cyc;
    @(negedge clk);
    issue(1'b1, 4'h1, 8'h10, 8'h01, 8'h0F, 4'b0000, 1'b1, g);
    chk("bp_gnt1_after_hs", g, hs + 1);
    after_op("bp_sub", 4'b0000);

    issue(1'b1, 4'h4, 8'h10, 8'h04, 8'h04, 4'b0000, 1'b1, g);
    after_op("div", 4'b0000);
    issue(1'b0, 4'h4, 8'h10, 8'h00, 8'hFF, 4'b0011, 1'b1, g);
    after_op("div0", 4'b0011);

    // Abort in EXEC: last completed grant was requester 0, so a surviving
    // last_grant would hand the tie to requester 1.
    issue(1'b0, 4'h0, 8'h40, 8'h40, 8'h80, 4'b0011, 1'b0, g);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid", rsp_valid, 1'b0);
    chk("abort_flags_q", flags_q, 4'h0);
    chk("abort_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1; chk("abort_no_rsp", rsp_valid, 1'b0);
    end
    @(negedge clk);
    fork
      issue(1'b0, 4'h0, 8'h02, 8'h03, 8'h05, 4'b0000, 1'b1, g0);
      issue(1'b1, 4'h1, 8'h02, 8'h03, 8'hFF, 4'b1001, 1'b1, g1);
    join
    chk("tie_req0_first", g1 - g0, 3);
    repeat (3) @(negedge clk);

    // Continuous contention from reset: RR alternates 0,1,0,1; fixed priority only 0.
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    fp_cnt = 0;
    req0 = 1'b1; op0 = 4'h0; a0 = 8'h01; b0 = 8'h01;
    req1 = 1'b1; op1 = 4'h1; a1 = 8'h03; b1 = 8'h05;
    for (int k = 0; k < 12; k++) begin
      #1;
      pat = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 1) ? 2'b10 : 2'b01);
      chk("rr_gnt", {gnt1, gnt0}, pat);
      chk("fp_no_gnt1", fp_gnt1, 1'b0);
      if (fp_gnt0) fp_cnt++;
      if (pat == 2'b01) sb.push_back({1'b0, 8'h02, 4'b0000});
      if (pat == 2'b10) sb.push_back({1'b1, 8'hFE, 4'b1001});
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("fp_gnt0_count", fp_cnt, 4);

    repeat (4) @(negedge clk);
    #1; chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
